// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared types for the pipeline hazard controller:
//   tHazState  - controller state (RUN, MEM_WAIT, FLUSH)
//   tFwdSel    - ALU operand source select (regfile, MEM result, WB result)
//   tStageTag  - destination tag carried alongside each in-flight instruction
// Register addresses are zero-extended into a TAG_ADDR_W-bit field, so the
// controller supports register files of up to 2**TAG_ADDR_W entries.
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

   localparam int unsigned TAG_ADDR_W = 8;
   localparam int unsigned FLUSH_CNT_W = 3;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FLUSH    = 2'd2
   } tHazState;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_MEM = 2'd1,
      FWD_WB  = 2'd2
   } tFwdSel;

   typedef struct packed {
      logic                  valid;
      logic [TAG_ADDR_W-1:0] rdAddr;
      logic                  rdWrEn;
      logic                  isLoad;
   } tStageTag;

   localparam tStageTag TAG_NONE = '0;

   // True when the tagged instruction will write a non-zero register equal to addr.
   function automatic logic tagWrites(input tStageTag tag, input logic [TAG_ADDR_W-1:0] addr);
      return tag.valid && tag.rdWrEn && (tag.rdAddr != '0) && (tag.rdAddr == addr);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_fwd_unit
// Purely combinational comparison of the ID-stage source registers against
// the EX and MEM destination tags.
// Ports:
//   iRs1Addr/iRs2Addr  ID source register addresses
//   iRs1Used/iRs2Used  ID instruction actually reads the source
//   iExTag/iMemTag     destination tags of the EX and MEM stages
//   oRs1Sel/oRs2Sel    next forwarding select (EX match wins over MEM match)
//   oLoadUse           ID reads the destination of a load sitting in EX
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl_fwd_unit
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] iRs1Addr,
   input  logic [REG_ADDR_W-1:0] iRs2Addr,
   input  logic                  iRs1Used,
   input  logic                  iRs2Used,
   input  tStageTag              iExTag,
   input  tStageTag              iMemTag,
   output tFwdSel                oRs1Sel,
   output tFwdSel                oRs2Sel,
   output logic                  oLoadUse
);

   logic [TAG_ADDR_W-1:0] rs1;
   logic [TAG_ADDR_W-1:0] rs2;
   logic                  rs1HitEx;
   logic                  rs2HitEx;
   logic                  rs1HitMem;
   logic                  rs2HitMem;
   logic                  unusedMemLoad;

   assign rs1 = TAG_ADDR_W'(iRs1Addr);
   assign rs2 = TAG_ADDR_W'(iRs2Addr);

   // x0 never matches: tagWrites rejects rdAddr == 0.
   assign rs1HitEx  = tagWrites(iExTag, rs1);
   assign rs2HitEx  = tagWrites(iExTag, rs2);
   assign rs1HitMem = tagWrites(iMemTag, rs1);
   assign rs2HitMem = tagWrites(iMemTag, rs2);

   // Load-ness of the MEM stage is irrelevant: its data is available by then.
   assign unusedMemLoad = iMemTag.isLoad;

   always_comb begin
      oRs1Sel = FWD_RF;
      oRs2Sel = FWD_RF;
      if (rs1HitEx) begin
         oRs1Sel = FWD_MEM;
      end else if (rs1HitMem) begin
         oRs1Sel = FWD_WB;
      end
      if (rs2HitEx) begin
         oRs2Sel = FWD_MEM;
      end else if (rs2HitMem) begin
         oRs2Sel = FWD_WB;
      end
      oLoadUse = iExTag.isLoad && ((iRs1Used && rs1HitEx) || (iRs2Used && rs2HitEx));
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Sequencing and hazard controller for the 5-stage integer pipeline.
// Tracks EX/MEM/WB destination tags, generates stall/flush/bubble/freeze
// controls and registered ALU forwarding selects.
// Ports:
//   iClk, iRst            clock, synchronous active-high reset
//   iId*                  description of the instruction in ID
//   iExBranchTaken        taken branch/jump resolved in EX (pulse)
//   iMemReq, iMemReady    data memory handshake from MEM
//   oStallIf, oStallId    hold PC + IF/ID, hold ID
//   oFlushId, oBubbleEx   clear IF/ID, insert bubble into ID/EX
//   oFreeze               hold EX/MEM and MEM/WB
//   oFwdRs1Sel/oFwdRs2Sel EX operand sources (0 regfile, 1 MEM, 2 WB)
//   oWbValid              WB tag valid, qualifies the regfile write
// Build option: define PIPE_PERF_CNT_EN to add oStallCnt and oFlushCnt,
// saturating counters of stall cycles and FLUSH entries.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned REG_ADDR_W   = 5
) (
   input  logic                  iClk,
   input  logic                  iRst,
   input  logic                  iIdValid,
   input  logic [REG_ADDR_W-1:0] iIdRs1Addr,
   input  logic [REG_ADDR_W-1:0] iIdRs2Addr,
   input  logic                  iIdRs1Used,
   input  logic                  iIdRs2Used,
   input  logic [REG_ADDR_W-1:0] iIdRdAddr,
   input  logic                  iIdRdWrEn,
   input  logic                  iIdIsLoad,
   input  logic                  iExBranchTaken,
   input  logic                  iMemReq,
   input  logic                  iMemReady,
   output logic                  oStallIf,
   output logic                  oStallId,
   output logic                  oFlushId,
   output logic                  oBubbleEx,
   output logic                  oFreeze,
   output logic [1:0]            oFwdRs1Sel,
   output logic [1:0]            oFwdRs2Sel,
`ifdef PIPE_PERF_CNT_EN
   output logic [31:0]           oStallCnt,
   output logic [31:0]           oFlushCnt,
`endif
   output logic                  oWbValid
);

   // The flush window includes the cycle the branch is seen in, so FLUSH
   // itself lasts FLUSH_CYCLES-1 cycles. A branch deferred by a memory wait
   // has not been flushed at all yet and owes the full FLUSH_CYCLES.
   localparam logic [FLUSH_CNT_W-1:0] FLUSH_FULL    = FLUSH_CNT_W'(FLUSH_CYCLES);
   localparam logic [FLUSH_CNT_W-1:0] FLUSH_RESTART = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

   tHazState              stateQ;
   tHazState              stateD;
   logic [FLUSH_CNT_W-1:0] flushRemQ;
   logic [FLUSH_CNT_W-1:0] flushRemD;
   logic                  pendBrQ;
   logic                  pendBrD;

   tStageTag              idTag;
   tStageTag              exTagQ;
   tStageTag              memTagQ;
   tStageTag              wbTagQ;

   tFwdSel                fwdRs1SelD;
   tFwdSel                fwdRs2SelD;
   tFwdSel                fwdRs1SelQ;
   tFwdSel                fwdRs2SelQ;

   logic                  loadUseRaw;
   logic                  memWaitEntry;
   logic                  loadUseStall;
   logic                  stallIf;
   logic                  stallId;
   logic                  flushId;
   logic                  bubbleEx;
   logic                  freeze;
   logic                  unusedWbBits;

   pipe_hazard_ctrl_fwd_unit #(
      .REG_ADDR_W (REG_ADDR_W)
   ) uFwdUnit (
      .iRs1Addr (iIdRs1Addr),
      .iRs2Addr (iIdRs2Addr),
      .iRs1Used (iIdRs1Used),
      .iRs2Used (iIdRs2Used),
      .iExTag   (exTagQ),
      .iMemTag  (memTagQ),
      .oRs1Sel  (fwdRs1SelD),
      .oRs2Sel  (fwdRs2SelD),
      .oLoadUse (loadUseRaw)
   );

   assign memWaitEntry = iMemReq && !iMemReady;

   always_comb begin
      idTag        = TAG_NONE;
      idTag.valid  = 1'b1;
      idTag.rdAddr = TAG_ADDR_W'(iIdRdAddr);
      idTag.rdWrEn = iIdRdWrEn;
      idTag.isLoad = iIdIsLoad;
   end

   // ---------------------------------------------------------------------
   // Controller FSM: next state and control outputs
   // ---------------------------------------------------------------------
   always_comb begin
      stateD       = stateQ;
      flushRemD    = flushRemQ;
      pendBrD      = pendBrQ;
      stallIf      = 1'b0;
      stallId      = 1'b0;
      flushId      = 1'b0;
      bubbleEx     = 1'b0;
      freeze       = 1'b0;
      loadUseStall = 1'b0;

      unique case (stateQ)
         RUN: begin
            if (memWaitEntry) begin
               // A branch seen now is deferred until the wait ends.
               stateD    = MEM_WAIT;
               pendBrD   = iExBranchTaken;
               flushRemD = iExBranchTaken ? FLUSH_FULL : '0;
            end else if (iExBranchTaken) begin
               flushId   = 1'b1;
               bubbleEx  = 1'b1;
               flushRemD = FLUSH_RESTART;
               stateD    = (FLUSH_RESTART != '0) ? FLUSH : RUN;
            end else if (loadUseRaw) begin
               // Branch above wins: a flushed ID instruction cannot hazard.
               loadUseStall = 1'b1;
               stallIf      = 1'b1;
               stallId      = 1'b1;
               bubbleEx     = 1'b1;
            end
         end

         FLUSH: begin
            flushId  = 1'b1;
            bubbleEx = 1'b1;
            if (memWaitEntry) begin
               // Remaining flush cycles are kept and resumed after the wait.
               stateD  = MEM_WAIT;
               pendBrD = 1'b1;
               if (iExBranchTaken) begin
                  flushRemD = FLUSH_FULL;
               end
            end else if (iExBranchTaken) begin
               flushRemD = FLUSH_RESTART;
               stateD    = (FLUSH_RESTART != '0) ? FLUSH : RUN;
            end else begin
               flushRemD = flushRemQ - FLUSH_CNT_W'(1);
               stateD    = (flushRemQ == FLUSH_CNT_W'(1)) ? RUN : FLUSH;
            end
         end

         MEM_WAIT: begin
            freeze  = 1'b1;
            stallIf = 1'b1;
            stallId = 1'b1;
            if (iMemReady) begin
               stateD  = pendBrQ ? FLUSH : RUN;
               pendBrD = 1'b0;
            end
         end

         default: begin
            stateD    = RUN;
            flushRemD = '0;
            pendBrD   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         stateQ    <= RUN;
         flushRemQ <= '0;
         pendBrQ   <= 1'b0;
      end else begin
         stateQ    <= stateD;
         flushRemQ <= flushRemD;
         pendBrQ   <= pendBrD;
      end
   end

   // ---------------------------------------------------------------------
   // Stage tags and forwarding selects
   // ---------------------------------------------------------------------
   always_ff @(posedge iClk) begin
      if (iRst) begin
         exTagQ     <= TAG_NONE;
         memTagQ    <= TAG_NONE;
         wbTagQ     <= TAG_NONE;
         fwdRs1SelQ <= FWD_RF;
         fwdRs2SelQ <= FWD_RF;
      end else if (!freeze) begin
         exTagQ  <= (iIdValid && !bubbleEx && !flushId) ? idTag : TAG_NONE;
         memTagQ <= exTagQ;
         wbTagQ  <= memTagQ;
         // A stalled ID instruction re-evaluates next cycle against the
         // advanced tags; keep the selects of the instruction now in EX.
         if (!stallId) begin
            fwdRs1SelQ <= fwdRs1SelD;
            fwdRs2SelQ <= fwdRs2SelD;
         end
      end
   end

   // Only the valid bit of the WB tag leaves the controller.
   assign unusedWbBits = ^{wbTagQ.rdAddr, wbTagQ.rdWrEn, wbTagQ.isLoad};

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stallCntQ;
   logic [31:0] flushCntQ;

   always_ff @(posedge iClk) begin
      if (iRst) begin
         stallCntQ <= '0;
         flushCntQ <= '0;
      end else begin
         if ((loadUseStall || freeze) && (stallCntQ != 32'hFFFF_FFFF)) begin
            stallCntQ <= stallCntQ + 32'd1;
         end
         if ((stateD == FLUSH) && (stateQ != FLUSH) && (flushCntQ != 32'hFFFF_FFFF)) begin
            flushCntQ <= flushCntQ + 32'd1;
         end
      end
   end

   assign oStallCnt = stallCntQ;
   assign oFlushCnt = flushCntQ;
`endif

   assign oStallIf   = stallIf;
   assign oStallId   = stallId;
   assign oFlushId   = flushId;
   assign oBubbleEx  = bubbleEx;
   assign oFreeze    = freeze;
   assign oFwdRs1Sel = fwdRs1SelQ;
   assign oFwdRs2Sel = fwdRs2SelQ;
   assign oWbValid   = wbTagQ.valid;

endmodule
